// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//
// Oversampling Philips I2S deserialiser. sck, ws and sd are synchronised into
// the clk domain and every rising edge of the synchronised sck is treated as a
// "bit event". No logic is clocked by sck itself.
//
// Ports:
//   clk          system clock (sck high/low phases must each be >= 3 clk)
//   rst          asynchronous, active-high reset
//   sck          I2S bit clock (asynchronous)
//   ws           I2S word select (asynchronous), 0 = left, 1 = right
//   sd           I2S serial data, MSB first (asynchronous)
//   left_data    last complete left sample, MSB-aligned
//   right_data   last complete right sample, MSB-aligned
//   sample_valid one-clk strobe: left_data/right_data hold a new stereo pair.
//                This is a plain strobe with no ready/back-pressure; the
//                consumer must take the pair while it is held (until the
//                next strobe).
//   locked       high once the first ws transition after reset was seen
//
// Pipeline (clk edges counted from the first edge that sees sck = 1):
//   edge 1  sck_s1 <= 1
//   edge 2  sck_s2 <= 1            -> bit_event asserted combinationally
//   edge 3  shift register / word end registered
//   edge 4  FSM acts on the registered word end (locked, outputs, strobe)
// -----------------------------------------------------------------------------
module i2s_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  locked
);

    typedef enum logic [0:0] {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DATA_WIDTH);

    // ---------------------------------------------------------------
    // Input synchronisers; sck_s3 is the edge-detect history stage.
    // ---------------------------------------------------------------
    logic sck_s1, sck_s2, sck_s3;
    logic ws_s1, ws_s2;
    logic sd_s1, sd_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            ws_s1  <= 1'b0;
            ws_s2  <= 1'b0;
            sd_s1  <= 1'b0;
            sd_s2  <= 1'b0;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            ws_s1  <= ws;
            ws_s2  <= ws_s1;
            sd_s1  <= sd;
            sd_s2  <= sd_s1;
        end
    end

    logic bit_event;
    logic ws_now;
    logic sd_bit;

    assign bit_event = sck_s2 & ~sck_s3;
    assign ws_now    = ws_s2;
    assign sd_bit    = sd_s2;

    // ---------------------------------------------------------------
    // Bit capture. The bit of each event belongs to channel ws_prev;
    // a change of ws marks that bit as the LSB slot of the word.
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  ws_prev;

    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [CNT_WIDTH-1:0]  shamt;
    logic [DATA_WIDTH-1:0] word_aligned;
    logic                  word_end;

    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        // Saturate: bits beyond DATA_WIDTH in long slots are dropped.
        if (bit_cnt < FULL_CNT) begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], sd_bit};
            cnt_nxt   = bit_cnt + CNT_WIDTH'(1);
        end
        // Short words are left-justified so unused LSBs read as zero.
        shamt        = FULL_CNT - cnt_nxt;
        word_aligned = shreg_nxt << shamt;
        word_end     = ws_now ^ ws_prev;
    end

    logic                  word_end_q;
    logic                  word_ch_q;
    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            ws_prev    <= 1'b0;
            word_end_q <= 1'b0;
            word_ch_q  <= 1'b0;
            word_q     <= '0;
        end else begin
            word_end_q <= 1'b0;
            if (bit_event) begin
                ws_prev    <= ws_now;
                word_end_q <= word_end;
                if (word_end) begin
                    word_q    <= word_aligned;
                    word_ch_q <= ws_prev;
                    shreg     <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shreg   <= shreg_nxt;
                    bit_cnt <= cnt_nxt;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Lock / pairing FSM
    // ---------------------------------------------------------------
    state_t state, state_next;
    logic   load_left;
    logic   load_pair;
    logic   left_pending;
    logic [DATA_WIDTH-1:0] left_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_left  = 1'b0;
        load_pair  = 1'b0;
        case (state)
            // The first word after reset is almost always partial: drop it.
            S_UNLOCKED: begin
                if (word_end_q) begin
                    state_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (word_end_q) begin
                    if (!word_ch_q) begin
                        load_left = 1'b1;
                    end else if (left_pending) begin
                        load_pair = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_UNLOCKED;
            end
        endcase
    end

    assign locked = (state == S_LOCKED);

    // A second left word before a right word simply overwrites left_hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_hold    <= '0;
            left_pending <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= load_pair;
            if (load_left) begin
                left_hold    <= word_q;
                left_pending <= 1'b1;
            end
            if (load_pair) begin
                left_data    <= left_hold;
                right_data   <= word_q;
                left_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
//
// Drives I2S frames as a queue of (channel, bit) slots and predicts the
// stereo pairs from whole-word rules: a word is the first DATA_WIDTH bits of
// its slot, MSB-aligned; the first word after reset is dropped; a right word
// produces a pair only if a left word is waiting.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int W = 24;
    localparam int BIG = 1000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         sck;
    logic         ws;
    logic         sd;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         sample_valid;
    logic         locked;

    i2s_receiver #(
        .DATA_WIDTH(W),
        .CNT_WIDTH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .ws          (ws),
        .sd          (sd),
        .left_data   (left_data),
        .right_data  (right_data),
        .sample_valid(sample_valid),
        .locked      (locked)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2*W-1:0] exp_q[$];
    logic [1:0]     strm_q[$];        // {channel, data bit}, one entry per sck period
    bit             m_locked;
    bit             m_pending;
    bit             m_have_prev;
    bit             m_prev_ch;
    logic [W-1:0]   m_left;
    logic [W-1:0]   m_prev_word;
    int             pairs_pushed = 0;

    function automatic logic [W-1:0] word_of(input logic [31:0] val, input int len);
        logic [31:0] m;
        m = (len >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> len);
        return W'((val & m) >> (32 - W));
    endfunction

    task automatic model_word_end(input bit ch, input logic [W-1:0] word);
        if (!m_locked) begin
            m_locked = 1'b1;
        end else if (!ch) begin
            m_left    = word;
            m_pending = 1'b1;
        end else if (m_pending) begin
            exp_q.push_back({m_left, word});
            pairs_pushed++;
            m_pending = 1'b0;
        end
    endtask

    // Slot value is MSB-first from bit 31; only len bits are sent.
    task automatic push_slot(input bit ch, input logic [31:0] val, input int len);
        if (m_have_prev && (m_prev_ch != ch)) model_word_end(m_prev_ch, m_prev_word);
        m_have_prev = 1'b1;
        m_prev_ch   = ch;
        m_prev_word = word_of(val, len);
        for (int i = 0; i < len; i++) strm_q.push_back({ch, val[31-i]});
    endtask

    // ---------------- driver ----------------
    int last_rlsb_cyc = 0;
    bit timing_en     = 1'b0;

    // ws leads the data by one sck period, so each entry is sent with the
    // channel of the following entry. The last entry stays queued until its
    // successor is known.
    task automatic play(input int half, input int limit);
        logic [1:0] e;
        logic [1:0] nxt;
        int n;
        n = 0;
        while (strm_q.size() > 1 && n < limit) begin
            e   = strm_q.pop_front();
            nxt = strm_q[0];
            @(negedge clk);
            sck = 1'b0;
            ws  = nxt[1];
            sd  = e[0];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            if (e[1] && !nxt[1]) last_rlsb_cyc = cyc;
            repeat (half - 1) @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset(input bit keep_stream);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_left_data", left_data, 0);
        check("rst_right_data", right_data, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_locked", locked, 0);
        m_locked  = 1'b0;
        m_pending = 1'b0;
        if (!keep_stream) begin
            strm_q.delete();
            m_have_prev = 1'b0;
        end
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Reset, then a partial left word and a short right word, which lock
    // the receiver without producing a pair.
    task automatic start_section();
        do_reset(1'b0);
        push_slot(1'b0, $urandom(), 5);
        push_slot(1'b1, $urandom(), 5);
    endtask

    // ---------------- scoreboard monitor ----------------
    int pulses = 0;

    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            logic [2*W-1:0] e;
            pulses <= pulses + 1;
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("left_data", left_data, e[2*W-1:W]);
                check("right_data", right_data, e[W-1:0]);
            end
            if (timing_en) check("pulse_time", cyc - last_rlsb_cyc, 4);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int base;
    int pair_base;
    int half;
    int lens[5] = '{16, 20, 24, 28, 32};

    initial begin
        rst = 1'b1;
        sck = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        repeat (3) @(negedge clk);
        check("init_left_data", left_data, 0);
        check("init_right_data", right_data, 0);
        check("init_sample_valid", sample_valid, 0);
        check("init_locked", locked, 0);
        rst = 1'b0;

        // Lock and discard: reset released mid left word, 32-bit slots.
        do_reset(1'b0);
        base = pulses;
        push_slot(1'b0, $urandom(), 12);
        push_slot(1'b1, $urandom(), 32);
        play(4, 11);
        repeat (6) @(negedge clk);
        check("lock_before_ws_edge", locked, 0);
        play(4, 1);
        repeat (6) @(negedge clk);
        check("lock_after_ws_edge", locked, 1);
        for (int f = 0; f < 4; f++) begin
            push_slot(1'b0, 32'hA5A5_A500, 32);
            push_slot(1'b1, 32'h5A5A_5A00, 32);
        end
        push_slot(1'b0, 32'h0, 2);
        play(4, BIG);
        drain("lock_drain");
        check("lock_pulses", pulses - base, 4);
        check("lock_left_value", left_data, 24'hA5A5A5);
        check("lock_right_value", right_data, 24'h5A5A5A);

        // Short 16-bit slots, then the same at the minimum clk/sck ratio.
        for (int pass = 0; pass < 2; pass++) begin
            half = (pass == 0) ? 5 : 3;
            start_section();
            base = pulses;
            for (int f = 0; f < 3; f++) begin
                push_slot(1'b0, 32'h8001_0000, 16);
                push_slot(1'b1, 32'h7FFF_0000, 16);
            end
            push_slot(1'b0, 32'h0, 2);
            play(half, BIG);
            drain("short_drain");
            check("short_pulses", pulses - base, 3);
            check("short_left_value", left_data, 24'h800100);
            check("short_right_value", right_data, 24'h7FFF00);
        end

        // Exact 24-bit slots, 100 frames, with strobe timing.
        start_section();
        base = pulses;
        timing_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            push_slot(1'b0, 32'hFFFF_FF00, 24);
            push_slot(1'b1, 32'h0000_0100, 24);
            play(3, BIG);
        end
        push_slot(1'b0, 32'h0, 2);
        play(3, BIG);
        drain("exact_drain");
        timing_en = 1'b0;
        check("exact_pulses", pulses - base, 100);
        check("exact_left_value", left_data, 24'hFFFFFF);
        check("exact_right_value", right_data, 24'h000001);

        // Missing left: the first full word after lock is a right word.
        do_reset(1'b0);
        base = pulses;
        push_slot(1'b0, $urandom(), 7);
        push_slot(1'b1, 32'h1234_5600, 24);
        push_slot(1'b0, 32'hABCD_EF00, 24);
        play(4, BIG);
        repeat (10) @(negedge clk);
        check("missing_left_no_pulse", pulses - base, 0);
        push_slot(1'b1, 32'h1357_9B00, 24);
        push_slot(1'b0, 32'h0, 2);
        play(4, BIG);
        drain("missing_left_drain");
        check("missing_left_pulses", pulses - base, 1);

        // Reset in the middle of a right word.
        start_section();
        base = pulses;
        push_slot(1'b0, $urandom(), 24);
        push_slot(1'b1, $urandom(), 24);
        push_slot(1'b0, $urandom(), 24);
        push_slot(1'b1, $urandom(), 24);
        play(4, strm_q.size() - 10);
        drain("midreset_pre_drain");
        check("midreset_pre_pulses", pulses - base, 1);
        do_reset(1'b1);
        play(4, BIG);
        push_slot(1'b0, $urandom(), 24);
        push_slot(1'b1, $urandom(), 24);
        push_slot(1'b0, 32'h0, 2);
        play(4, BIG);
        drain("midreset_post_drain");
        check("midreset_pulses", pulses - base, 2);

        // Random values, slot lengths and clock ratios.
        start_section();
        base      = pulses;
        pair_base = pairs_pushed;
        for (int f = 0; f < 12; f++) begin
            push_slot(1'b0, $urandom(), lens[$urandom_range(0, 4)]);
            push_slot(1'b1, $urandom(), lens[$urandom_range(0, 4)]);
            play(int'($urandom_range(3, 5)), BIG);
        end
        push_slot(1'b0, 32'h0, 2);
        play(4, BIG);
        drain("random_drain");
        check("random_pulses", pulses - base, pairs_pushed - pair_base);
        check("random_locked", locked, 1);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
